// File: rtl/procb_buf_pkg.sv
// procb_buf_pkg
//   Shared definitions for the process_bytes record buffer: record layout,
//   default depth and a small helper that turns a maximum value into the
//   MSB index needed to hold it.
package procb_buf_pkg;

  // Record layout: {addr, bytes_cnt, finish_ctx}, addr in the top bits.
  localparam int PROCB_ADDR_W   = 16;
  localparam int PROCB_CNT_W    = 8;
  localparam int PROCB_D_WIDTH  = PROCB_ADDR_W + PROCB_CNT_W + 1;

  // Field positions inside a packed record.
  localparam int PROCB_FIN_LSB  = 0;
  localparam int PROCB_CNT_LSB  = 1;
  localparam int PROCB_ADDR_LSB = PROCB_CNT_LSB + PROCB_CNT_W;

  // Default number of records held per thread.
  localparam int PROCB_DEPTH_DEF = 4;

  typedef struct packed {
    logic [PROCB_ADDR_W-1:0] addr;
    logic [PROCB_CNT_W-1:0]  bytes_cnt;
    logic                    finish_ctx;
  } procb_rec_t;

  // Index of the highest set bit of v (0 for v <= 1), i.e. the MSB index of
  // a counter whose largest value is v.
  function automatic int msb(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((v >> i) & 1) != 0) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/procb_buf_ptrs.sv
// procb_buf_ptrs
//   Pointer set of one thread's FIFO partition: write, commit (rd) and
//   lookup pointers, each with one extra wrap bit so full and empty are
//   distinguishable.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   wr_inc_i         accept one record at the write pointer
//   lk_inc_i         advance the lookup pointer
//   commit_i         retire the oldest looked-up record
//   rollback_i       return the lookup pointer to the commit pointer
//   clr_i            clear all pointers (wins over every other strobe)
//   wr_idx_o         RAM slot of the next write
//   lk_idx_o         RAM slot of the next lookup
//   full_o           registered full flag
//   empty_o          nothing left to look up
module procb_buf_ptrs
  import procb_buf_pkg::*;
#(
  parameter int PROCB_DEPTH     = PROCB_DEPTH_DEF,
  parameter int PROCB_DEPTH_MSB = msb(PROCB_DEPTH - 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_inc_i,
  input  logic                     lk_inc_i,
  input  logic                     commit_i,
  input  logic                     rollback_i,
  input  logic                     clr_i,
  output logic [PROCB_DEPTH_MSB:0] wr_idx_o,
  output logic [PROCB_DEPTH_MSB:0] lk_idx_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = PROCB_DEPTH_MSB + 2;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(PROCB_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] lk_ptr_q, lk_ptr_d;
  logic             full_q, full_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_inc_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(commit_i);
    // Rollback restores the pre-commit rd pointer; a lookup is never
    // accepted in a rollback cycle so the two cannot collide.
    lk_ptr_d = rollback_i ? rd_ptr_q : (lk_ptr_q + PTR_W'(lk_inc_i));
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lk_ptr_d = '0;
    end
    // Full follows the updated pointers so a write and a commit on the
    // same edge are both reflected.
    full_d = ((wr_ptr_d - rd_ptr_d) == DEPTH_P);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lk_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lk_ptr_q <= lk_ptr_d;
      full_q   <= full_d;
    end
  end

  assign wr_idx_o = wr_ptr_q[PROCB_DEPTH_MSB:0];
  assign lk_idx_o = lk_ptr_q[PROCB_DEPTH_MSB:0];
  assign full_o   = full_q;
  assign empty_o  = (lk_ptr_q == wr_ptr_q);

endmodule

// File: rtl/procb_buf.sv
// procb_buf
//   Per-thread FIFO of process_bytes records. The writer pushes records
//   tagged with a thread number; the reader looks records up ahead of time
//   and commits or discards each lookup on the following cycle.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   wr_thread_num   thread written by wr_en/din
//   wr_en, din      write strobe and record
//   full            per-thread registered full flags
//   rd_thread_num   thread served by the reader
//   lookup_en       take the record at the lookup pointer
//   rd_en           commit the lookup made on the previous cycle
//   rd_rst          clear all pointers of rd_thread_num
//   lookup_empty    no record left to look up for rd_thread_num
//   dout            record at the lookup pointer of rd_thread_num
//   err             sticky protocol error
module procb_buf
  import procb_buf_pkg::*;
#(
  parameter int N_THREADS       = 4,
  parameter int N_THREADS_MSB   = msb(N_THREADS - 1),
  parameter int PROCB_DEPTH     = PROCB_DEPTH_DEF,
  parameter int PROCB_DEPTH_MSB = msb(PROCB_DEPTH - 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_THREADS_MSB:0]   wr_thread_num,
  input  logic                     wr_en,
  input  logic [PROCB_D_WIDTH-1:0] din,
  output logic [N_THREADS-1:0]     full,
  input  logic [N_THREADS_MSB:0]   rd_thread_num,
  input  logic                     lookup_en,
  input  logic                     rd_en,
  input  logic                     rd_rst,
  output logic                     lookup_empty,
  output logic [PROCB_D_WIDTH-1:0] dout,
  output logic                     err
);

  localparam int THR_W = N_THREADS_MSB + 1;
  localparam int IDX_W = PROCB_DEPTH_MSB + 1;

  logic [N_THREADS-1:0][IDX_W-1:0] wr_idx;
  logic [N_THREADS-1:0][IDX_W-1:0] lk_idx;
  logic [N_THREADS-1:0]            full_v;
  logic [N_THREADS-1:0]            empty_v;

  logic             pending_q, pending_d;
  logic [THR_W-1:0] pend_thr_q, pend_thr_d;
  logic             err_q, err_d;

  logic same_thr;
  logic wr_ok;
  logic commit_now;
  logic rollback_now;
  logic lookup_ok;

  assign lookup_empty = empty_v[rd_thread_num];
  assign full         = full_v;
  assign err          = err_q;

  // rd_rst on the thread being written swallows the write.
  assign same_thr     = (wr_thread_num == rd_thread_num);
  assign wr_ok        = wr_en & ~full_v[wr_thread_num] & ~(rd_rst & same_thr);
  assign commit_now   = pending_q & rd_en;
  assign rollback_now = pending_q & ~rd_en;
  // A lookup in a rollback cycle would race the pointer restore; refuse it.
  assign lookup_ok    = lookup_en & ~lookup_empty & ~rollback_now & ~rd_rst;

  always_comb begin
    pending_d  = lookup_ok;
    pend_thr_d = lookup_ok ? rd_thread_num : pend_thr_q;
    err_d      = err_q;
    if (wr_en & full_v[wr_thread_num] & ~(rd_rst & same_thr)) err_d = 1'b1;
    if (~rd_rst) begin
      if (lookup_en & (lookup_empty | rollback_now)) err_d = 1'b1;
      if (rd_en & ~pending_q) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q  <= 1'b0;
      pend_thr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      pend_thr_q <= pend_thr_d;
      err_q      <= err_d;
    end
  end

  // One pointer set per thread, each fed with strobes decoded for it.
  generate
    for (genvar gi = 0; gi < N_THREADS; gi++) begin : g_thr
      logic wr_sel, rd_sel, pd_sel;
      assign wr_sel = (wr_thread_num == THR_W'(gi));
      assign rd_sel = (rd_thread_num == THR_W'(gi));
      assign pd_sel = (pend_thr_q == THR_W'(gi));

      procb_buf_ptrs #(
        .PROCB_DEPTH     (PROCB_DEPTH),
        .PROCB_DEPTH_MSB (PROCB_DEPTH_MSB)
      ) u_ptrs (
        .clk_i      (CLK),
        .rst_i      (RST),
        .wr_inc_i   (wr_ok & wr_sel),
        .lk_inc_i   (lookup_ok & rd_sel),
        .commit_i   (commit_now & pd_sel),
        .rollback_i (rollback_now & pd_sel),
        .clr_i      (rd_rst & rd_sel),
        .wr_idx_o   (wr_idx[gi]),
        .lk_idx_o   (lk_idx[gi]),
        .full_o     (full_v[gi]),
        .empty_o    (empty_v[gi])
      );
    end
  endgenerate

  // Distributed RAM: thread number selects the partition, pointer the slot.
  // Read is asynchronous so dout tracks the lookup pointer with no latency.
  logic [PROCB_D_WIDTH-1:0] mem_q [N_THREADS*PROCB_DEPTH];
  logic [THR_W+IDX_W-1:0]   wr_addr;
  logic [THR_W+IDX_W-1:0]   rd_addr;

  assign wr_addr = {wr_thread_num, wr_idx[wr_thread_num]};
  assign rd_addr = {rd_thread_num, lk_idx[rd_thread_num]};

  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[wr_addr] <= din;
  end

  assign dout = mem_q[rd_addr];

endmodule

// File: tb/tb_procb_buf.sv
module tb_procb_buf;
  import procb_buf_pkg::*;

  localparam int NT  = 4;
  localparam int TW  = 2;
  localparam int DEP = 4;
  localparam int W   = PROCB_D_WIDTH;

  logic          CLK = 1'b0;
  logic          RST;
  logic [TW-1:0] wr_thread_num;
  logic          wr_en;
  logic [W-1:0]  din;
  logic [NT-1:0] full;
  logic [TW-1:0] rd_thread_num;
  logic          lookup_en;
  logic          rd_en;
  logic          rd_rst;
  logic          lookup_empty;
  logic [W-1:0]  dout;
  logic          err;

  procb_buf #(
    .N_THREADS   (NT),
    .PROCB_DEPTH (DEP)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .wr_thread_num (wr_thread_num),
    .wr_en         (wr_en),
    .din           (din),
    .full          (full),
    .rd_thread_num (rd_thread_num),
    .lookup_en     (lookup_en),
    .rd_en         (rd_en),
    .rd_rst        (rd_rst),
    .lookup_empty  (lookup_empty),
    .dout          (dout),
    .err           (err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Scoreboard: records the reader should see, in lookup order.
  logic [W-1:0] rec_q[$];
  logic [W-1:0] mon_exp;

  // Reference model: per-thread queue of stored records (oldest first) and
  // how many of them are currently looked up but not committed.
  logic [W-1:0] mf[NT][$];
  int           looked[NT];
  bit           mpend;
  int           mpthr;
  bit           merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int addr, input int cnt, input bit fin);
    procb_rec_t r;
    r.addr       = addr[PROCB_ADDR_W-1:0];
    r.bytes_cnt  = cnt[PROCB_CNT_W-1:0];
    r.finish_ctx = fin;
    return r;
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < NT; t++) begin
      mf[t].delete();
      looked[t] = 0;
    end
    mpend = 0;
    mpthr = 0;
    merr  = 0;
  endfunction

  // Monitor: whenever the DUT accepts a lookup, dout must be the next
  // record the model predicted.
  always @(negedge CLK) begin
    if (RST === 1'b0 && lookup_en === 1'b1 && lookup_empty === 1'b0) begin
      if (rec_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout: got %0h expected no lookup at %0t", dout, $time);
      end else begin
        mon_exp = rec_q.pop_front();
        chk("dout", dout, mon_exp);
      end
    end
  end

  // One clock cycle: drive inputs (called at posedge+1), check status
  // against the model, advance the model, wait for the edge.
  task automatic cyc(input bit we, input int wt, input logic [W-1:0] d,
                     input int rt, input bit le, input bit re, input bit rr);
    logic [NT-1:0] fexp;
    bit rb, acc, wpush, cp;
    int ct;
    wr_en = we; wr_thread_num = wt[TW-1:0]; din = d;
    rd_thread_num = rt[TW-1:0]; lookup_en = le; rd_en = re; rd_rst = rr;
    #1;
    for (int t = 0; t < NT; t++) fexp[t] = (mf[t].size() == DEP);
    chk("full", full, fexp);
    chk("err", err, merr);
    chk("lookup_empty", lookup_empty, looked[rt] == mf[rt].size());
    if (rr) begin
      mf[rt].delete();
      looked[rt] = 0;
      mpend = 0;
    end else begin
      cp = mpend; ct = mpthr;
      rb = cp && !re;
      acc = 0; wpush = 0;
      if (le) begin
        if (rb || looked[rt] == mf[rt].size()) merr = 1;
        else begin
          acc = 1;
          rec_q.push_back(mf[rt][looked[rt]]);
        end
      end
      if (we) begin
        if (mf[wt].size() == DEP) merr = 1;
        else wpush = 1;
      end
      if (re && !cp) merr = 1;
      if (cp && re) begin
        void'(mf[ct].pop_front());
        looked[ct]--;
      end
      if (rb) looked[ct] = 0;
      if (acc) looked[rt]++;
      if (wpush) mf[wt].push_back(d);
      mpend = acc;
      if (acc) mpthr = rt;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    wr_en = 0; lookup_en = 0; rd_en = 0; rd_rst = 0;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  logic [W-1:0] ra, rb_r;
  bit r_we, r_le, r_re, r_rr;
  int r_wt, r_rt;

  initial begin
    RST = 1'b1;
    wr_en = 0; wr_thread_num = 0; din = '0;
    rd_thread_num = 0; lookup_en = 0; rd_en = 0; rd_rst = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_lookup_empty", lookup_empty, 1);
    RST = 1'b0;

    // Three records to thread 2, popped in order.
    cyc(1, 2, mk(16'h100, 5, 0), 2, 0, 0, 0);
    cyc(1, 2, mk(16'h200, 9, 0), 2, 0, 0, 0);
    cyc(1, 2, mk(16'h300, 16, 1), 2, 0, 0, 0);
    chk("t2_visible", lookup_empty, 0);
    cyc(0, 0, '0, 2, 1, 0, 0);
    cyc(0, 0, '0, 2, 1, 1, 0);
    cyc(0, 0, '0, 2, 1, 1, 0);
    chk("t2_drained", lookup_empty, 1);
    cyc(0, 0, '0, 2, 0, 1, 0);

    // Rollback on thread 0: the same record comes back.
    ra = mk(16'hA0A0, 1, 0); rb_r = mk(16'hB0B0, 2, 1);
    cyc(1, 0, ra, 0, 0, 0, 0);
    cyc(1, 0, rb_r, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0, 0);
    cyc(0, 0, '0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0, 0);
    cyc(0, 0, '0, 0, 1, 1, 0);
    cyc(0, 0, '0, 0, 0, 1, 0);
    chk("t0_drained", lookup_empty, 1);

    // Back-to-back lookups with commits.
    cyc(1, 0, ra, 0, 0, 0, 0);
    cyc(1, 0, rb_r, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0, 0);
    cyc(0, 0, '0, 0, 1, 1, 0);
    cyc(0, 0, '0, 0, 0, 1, 0);
    chk("b2b_empty", lookup_empty, 1);
    chk("b2b_err", err, 0);
    chk("b2b_full0", full[0], 0);

    // Lookup on empty thread 3, then a stray rd_en.
    cyc(0, 0, '0, 3, 1, 0, 0);
    chk("empty_lookup_err", err, 1);
    cyc(0, 0, '0, 3, 0, 1, 0);
    chk("stray_rd_err", err, 1);
    chk("stray_rd_empty", lookup_empty, 1);

    // Fill thread 1, overflow, then free one slot.
    for (int i = 0; i < DEP; i++) cyc(1, 1, mk(16'h1000 + i, i + 3, 0), 1, 0, 0, 0);
    chk("t1_full", full[1], 1);
    cyc(1, 1, mk(16'hDEAD, 7, 1), 1, 0, 0, 0);
    chk("overflow_err", err, 1);
    cyc(0, 0, '0, 1, 1, 0, 0);
    cyc(0, 0, '0, 1, 0, 1, 0);
    chk("t1_not_full", full[1], 0);

    // Asynchronous reset in the middle of a write burst.
    cyc(1, 0, mk(16'h5000, 1, 0), 0, 0, 0, 0);
    cyc(1, 0, mk(16'h5001, 2, 0), 0, 0, 0, 0);
    wr_en = 1; wr_thread_num = 0; din = mk(16'h5002, 3, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("async_full", full, 0);
    chk("async_err", err, 0);
    chk("async_empty", lookup_empty, 1);
    model_reset();
    wr_en = 0;
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // rd_rst on thread 2 leaves thread 1 intact.
    cyc(1, 2, mk(16'h2200, 4, 0), 2, 0, 0, 0);
    cyc(1, 2, mk(16'h2201, 5, 0), 2, 0, 0, 0);
    cyc(1, 1, mk(16'h1100, 6, 1), 2, 0, 0, 0);
    cyc(1, 1, mk(16'h1101, 7, 0), 2, 0, 0, 0);
    cyc(0, 0, '0, 2, 0, 0, 1);
    chk("rdrst_t2_empty", lookup_empty, 1);
    cyc(0, 0, '0, 1, 1, 0, 0);
    cyc(0, 0, '0, 1, 0, 1, 0);
    chk("t1_left", lookup_empty, 0);

    // Randomised traffic against the model, reset every 100 cycles.
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 99) do_reset();
      r_rr = !mpend && ($urandom_range(0, 24) == 0);
      r_rt = $urandom_range(0, NT - 1);
      if (r_rr) begin
        cyc(0, 0, '0, r_rt, 0, 0, 1);
      end else begin
        r_we = ($urandom_range(0, 2) != 0);
        r_wt = $urandom_range(0, NT - 1);
        r_le = ($urandom_range(0, 1) != 0);
        r_re = mpend ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
        if (mpend && !r_re) r_le = 0;
        cyc(r_we, r_wt, W'($urandom), r_rt, r_le, r_re, 0);
      end
    end

    cyc(0, 0, '0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0, 0);
    chk("scoreboard_drained", rec_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/procb_buf.md
Name: procb_buf

Overview:
- Per-thread FIFO store of process_bytes (procb) records; the responder end of the procb record interface.
- Write side: records arrive from the CPU/command side, tagged with a thread number.
- Read side: process_bytes browses records ahead of time with lookup, then commits (pops) or discards each lookup one cycle later.
- Storage is distributed RAM, N_THREADS partitions of PROCB_DEPTH entries each.

Parameters:
- N_THREADS, `N_THREADS, number of threads (power of 2).
- N_THREADS_MSB, `MSB(N_THREADS-1), thread-number MSB.
- PROCB_DEPTH, 4, records per thread (power of 2, ≥2).
- PROCB_DEPTH_MSB, `MSB(PROCB_DEPTH-1), pointer index MSB.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- wr_thread_num  in  N_THREADS_MSB+1  thread being written.
- wr_en  in  1  write din into wr_thread_num's FIFO.
- din  in  `PROCB_D_WIDTH  record {addr, bytes_cnt, finish_ctx}.
- full  out  N_THREADS  per-thread full flags (registered).
- rd_thread_num  in  N_THREADS_MSB+1  thread currently served by process_bytes.
- lookup_en  in  1  advance lookup pointer of rd_thread_num.
- rd_en  in  1  commit the lookup made on the previous cycle.
- rd_rst  in  1  clear all pointers of rd_thread_num.
- lookup_empty  out  1  no unlooked record for rd_thread_num.
- dout  out  `PROCB_D_WIDTH  record at lookup pointer of rd_thread_num.
- err  out  1  sticky protocol error.

Behaviour:
- Per-thread pointers are (PROCB_DEPTH_MSB+2) bits wide, with one extra wrap bit:
  - wr_ptr: next write slot.
  - rd_ptr: oldest uncommitted record.
  - lk_ptr: next record to look up.
- Invariant: rd_ptr ≤ lk_ptr ≤ wr_ptr, all modulo 2*PROCB_DEPTH.
- Reset (RST=1, async):
  - All pointers = 0, full = 0, err = 0, pending = 0.
  - lookup_empty = 1.
  - dout is undefined (RAM is not cleared).
- Write:
  - wr_en & ~full[t]: mem[t][wr_ptr] <= din; wr_ptr[t]++.
  - full[t] = (wr_ptr[t] - rd_ptr[t]) == PROCB_DEPTH. It is registered and updated on the same edge as the pointers.
  - wr_en & full[t]: write ignored, err <= 1.
- Read-side outputs (combinational from registered pointers and rd_thread_num; zero added latency):
  - lookup_empty = (lk_ptr[rd_thread_num] == wr_ptr[rd_thread_num]).
  - dout = mem[rd_thread_num][lk_ptr[rd_thread_num]].
- A record written at edge N is visible (lookup_empty=0) after edge N.
- Lookup:
  - lookup_en & ~lookup_empty: lk_ptr[rd_thread_num]++.
  - Also pending <= 1 and pend_thr <= rd_thread_num.
  - dout in the lookup cycle is the record being taken.
- Lookup on empty: ignored, err <= 1.
- Resolution in the cycle after a lookup (pending=1):
  - rd_en=1: rd_ptr[pend_thr]++ (commit).
  - rd_en=0: lk_ptr[pend_thr] <= rd_ptr[pend_thr] (rollback). Any concurrent lookup_en in that cycle is ignored and sets err.
  - pending <= lookup_en (back-to-back lookups are allowed when each is committed).
- rd_en while pending=0: ignored, err <= 1.
- Back-to-back sequence: lookup(t), rd_en+lookup(t+1), rd_en(t+2) commits two records in order.
- rd_rst: rd_ptr, lk_ptr and wr_ptr of rd_thread_num <= 0, and pending <= 0.
  - rd_rst overrides a same-cycle lookup, rd_en or write to that thread.
  - The FSM for rd_rst is driven per thread over N_THREADS cycles by the consumer during its init.
- Simultaneous events on one thread:
  - Write and commit on the same edge both apply; full is recomputed from both updated pointers.
  - Write to thread A and lookup on thread B are independent.
- RAM write port uses {wr_thread_num, wr_ptr[idx]}; the read port is asynchronous (DISTRIBUTED).

Decomposition:
- Shared package (sha512.vh): PROCB_D_WIDTH, PROCB_DEPTH, plus field macros for record layout (addr, cnt, finish_ctx).
- One sub-module, procb_ptrs: per-thread pointer set with lookup/commit/rollback/rst logic and full/empty compare.
- procb_buf instantiates the RAM and the pending/err logic.

Test Plan:
- Reset, then write 3 records (cnt=5,9,16) to thread 2; set rd_thread_num=2 -> lookup_empty=0 one cycle after the last write. lookup+rd_en sequences pop them in order; lookup_empty=1 after the third lookup.
- Write 4 records to thread 1 (PROCB_DEPTH=4) -> full[1]=1; a 5th write is ignored and err=1. Commit 1 -> full[1]=0 next cycle.
- Thread 0 holds records A,B; lookup (dout=A), then rd_en=0 -> rollback; the next lookup again gives dout=A, and rd_ptr is unchanged.
- Back-to-back: lookup A (t), lookup B + rd_en (t+1), rd_en (t+2) -> both committed, FIFO empty, err=0.
- Lookup on empty thread 3 -> err=1, pointers unchanged. rd_en without a prior lookup -> err stays 1, no pointer change.
- Pulse RST mid-write burst -> all flags reset immediately and asynchronously. rd_rst on thread 2 with 2 stored records -> lookup_empty=1 for thread 2; thread 1 contents intact.
